// File: rtl/lzc_pkg.sv
// Shared definitions for the leading-zero normalizer/expander datapath.
package lzc_pkg;

  localparam int unsigned LZC_WIDTH = 8;
  localparam int unsigned LZC_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } lzc_state_e;

endpackage

// File: rtl/lzc_expander.sv
// Iterative inverse of the leading-zero normalizer: val = mant >> count,
// one right shift per clock, valid/ready on both sides.
module lzc_expander
  import lzc_pkg::*;
#(
  parameter int unsigned WIDTH = LZC_WIDTH,
  parameter int unsigned CNT_W = LZC_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] in_count,
  input  logic [WIDTH-1:0] in_mant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val,
  output logic             out_err
);

  lzc_state_e       state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] rem;
  logic             err;

  // Shift register doubles as the output register; it only matters in DONE.
  assign out_val = shreg;
  assign out_err = err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      rem       <= '0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shreg    <= in_mant;
            rem      <= in_count;
            err      <= (in_mant != '0) && !in_mant[WIDTH-1];
            in_ready <= 1'b0;
            if (in_count == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          shreg <= shreg >> 1;
          rem   <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // No same-cycle handoff: IDLE is re-entered before the next accept.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lzc_expander.sv
// Directed self-checking bench for lzc_expander, including a full round trip
// against a behavioural leading-zero normalizer.
module tb_lzc_expander;
  import lzc_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_count;
  logic [7:0] in_mant;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_val;
  logic       out_err;

  int total = 0;
  int bad   = 0;

  lzc_expander dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference leading-zero count; zero maps to count 0.
  function automatic logic [2:0] lzc_ref(input logic [7:0] v);
    logic [2:0] n;
    n = 3'd0;
    if (v != 8'h00) begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) break;
        n = n + 3'd1;
      end
    end
    return n;
  endfunction

  // Offer one pair from IDLE and wait (bounded) for out_valid; lat=-1 on timeout.
  task automatic xfer(input logic [2:0] c, input logic [7:0] m,
                      output logic [7:0] v, output logic e, output int lat);
    in_count = c;
    in_mant  = m;
    in_valid = 1'b1;
    lat = -1;
    v   = 8'hxx;
    e   = 1'bx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) in_valid = 1'b0;
      if (out_valid) begin
        lat = k;
        v   = out_val;
        e   = out_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_val !== 8'h00 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL reset: in_ready=%b out_valid=%b out_val=%h out_err=%b, want 1 0 00 0",
               in_ready, out_valid, out_val, out_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    logic [7:0] v; logic e; int lat;
    xfer(3'd3, 8'hA0, v, e, lat);
    total++;
    if (v !== 8'h14 || e !== 1'b0 || lat != 3) begin
      bad++;
      $display("FAIL basic_c3_a0: val=%h err=%b lat=%0d, want 14 0 3", v, e, lat);
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_return_idle: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_shift_bounds();
    logic [7:0] v; logic e; int lat;
    xfer(3'd0, 8'h80, v, e, lat);
    total++;
    if (v !== 8'h80 || e !== 1'b0 || lat != 0) begin
      bad++;
      $display("FAIL count0: val=%h err=%b lat=%0d, want 80 0 0", v, e, lat);
    end
    @(negedge clk);
    xfer(3'd7, 8'h80, v, e, lat);
    total++;
    if (v !== 8'h01 || e !== 1'b0 || lat != 7) begin
      bad++;
      $display("FAIL count7: val=%h err=%b lat=%0d, want 01 0 7", v, e, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [7:0] v; logic e; int lat;
    out_ready = 1'b0;
    xfer(3'd2, 8'hC0, v, e, lat);
    total++;
    if (v !== 8'h30 || lat != 2) begin
      bad++;
      $display("FAIL bp_first: val=%h lat=%0d, want 30 2", v, lat);
    end
    // Second pair offered while the first result is stalled.
    in_count = 3'd1;
    in_mant  = 8'h80;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_val !== 8'h30 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: out_valid=%b out_val=%h in_ready=%b, want 1 30 0",
                 i, out_valid, out_val, in_ready);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_handoff: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_second_accept: in_ready=%b, want 0", in_ready);
    end
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) begin lat = k; break; end
      @(negedge clk);
    end
    total++;
    if (lat != 1 || out_val !== 8'h40 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL bp_second: val=%h err=%b wait=%0d, want 40 0 1", out_val, out_err, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_err_zero();
    logic [7:0] v; logic e; int lat;
    xfer(3'd1, 8'h40, v, e, lat);
    total++;
    if (v !== 8'h20 || e !== 1'b1 || lat != 1) begin
      bad++;
      $display("FAIL err_c1_40: val=%h err=%b lat=%0d, want 20 1 1", v, e, lat);
    end
    @(negedge clk);
    xfer(3'd5, 8'h00, v, e, lat);
    total++;
    if (v !== 8'h00 || e !== 1'b0 || lat != 5) begin
      bad++;
      $display("FAIL zero_c5: val=%h err=%b lat=%0d, want 00 0 5", v, e, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_round_trip();
    logic [7:0] v; logic e; int lat;
    logic [7:0] val;
    logic [2:0] c;
    for (int i = 0; i < 256; i++) begin
      val = 8'(i);
      c   = lzc_ref(val);
      xfer(c, val << c, v, e, lat);
      total++;
      if (v !== val || e !== 1'b0 || lat != int'(c)) begin
        bad++;
        $display("FAIL round_trip_%h: val=%h err=%b lat=%0d, want %h 0 %0d", val, v, e, lat, val, c);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    in_count = 3'd7;
    in_mant  = 8'h80;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (dut.state !== SHIFT) begin
      bad++;
      $display("FAIL mid_in_shift: state=%0d, want %0d", dut.state, SHIFT);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (dut.state !== IDLE || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset: state=%0d out_valid=%b in_ready=%b, want %0d 0 1",
               dut.state, out_valid, in_ready, IDLE);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL mid_no_output: out_valid=%b at cycle %0d, want 0", out_valid, k);
        break;
      end
    end
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_idle: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_count  = 3'd0;
    in_mant   = 8'h00;
    out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_shift_bounds();
    test_backpressure();
    test_err_zero();
    test_round_trip();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
